// File: rtl/interrupt_controller.sv
// Interrupt entry sequencer: synchronises and edge-detects irq_in, drains the pipeline,
// pushes the resume PC (high then low word) and the flags, loads the vector, and blocks nesting until RTI.
module interrupt_controller #(
  parameter int unsigned          PC_WIDTH    = 32,
  parameter int unsigned          FLAG_WIDTH  = 3,
  parameter logic [PC_WIDTH-1:0]  VECTOR_ADDR = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  irq_in,
  input  logic                  pipeline_busy,
  input  logic [PC_WIDTH-1:0]   pc_current,
  input  logic [FLAG_WIDTH-1:0] flags_in,
  input  logic                  push_ready,
  input  logic                  rti_retire,
  output logic                  stall_fetch,
  output logic                  flush_decode,
  output logic                  push_valid,
  output logic [15:0]           push_data,
  output logic                  pc_load,
  output logic [PC_WIDTH-1:0]   pc_load_value,
  output logic                  in_service,
  output logic                  irq_pending
);

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    PUSH_HI,
    PUSH_LO,
    PUSH_FL,
    VECTOR,
    SERVICE
  } state_t;

  state_t                state_q, state_d;
  logic                  sync1, sync2, sync2_d;
  logic                  pending_q;
  logic [PC_WIDTH-1:0]   pc_q;
  logic [FLAG_WIDTH-1:0] flags_q;
  logic                  rise;
  logic                  capture;

  assign rise    = sync2 & ~sync2_d;
  assign capture = (state_q == DRAIN) && !pipeline_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      sync2_d   <= 1'b0;
      pending_q <= 1'b0;
      pc_q      <= '0;
      flags_q   <= '0;
    end else begin
      state_q <= state_d;
      sync1   <= irq_in;
      sync2   <= sync1;
      sync2_d <= sync2;
      if (capture) begin
        pc_q    <= pc_current;
        flags_q <= flags_in;
      end
      // A fresh rise outranks the clear so a request arriving on the capture cycle is not lost.
      if (rise)
        pending_q <= 1'b1;
      else if (capture)
        pending_q <= 1'b0;
    end
  end

  always_comb begin
    state_d       = state_q;
    stall_fetch   = 1'b0;
    flush_decode  = 1'b0;
    push_valid    = 1'b0;
    push_data     = '0;
    pc_load       = 1'b0;
    pc_load_value = '0;
    in_service    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pending_q || rise)
          state_d = DRAIN;
      end
      DRAIN: begin
        stall_fetch  = 1'b1;
        flush_decode = 1'b1;
        if (!pipeline_busy)
          state_d = PUSH_HI;
      end
      PUSH_HI: begin
        stall_fetch = 1'b1;
        push_valid  = 1'b1;
        push_data   = pc_q[31:16];
        if (push_ready)
          state_d = PUSH_LO;
      end
      PUSH_LO: begin
        stall_fetch = 1'b1;
        push_valid  = 1'b1;
        push_data   = pc_q[15:0];
        if (push_ready)
          state_d = PUSH_FL;
      end
      PUSH_FL: begin
        stall_fetch = 1'b1;
        push_valid  = 1'b1;
        push_data   = {{(16 - FLAG_WIDTH){1'b0}}, flags_q};
        if (push_ready)
          state_d = VECTOR;
      end
      VECTOR: begin
        stall_fetch   = 1'b1;
        pc_load       = 1'b1;
        pc_load_value = VECTOR_ADDR;
        state_d       = SERVICE;
      end
      SERVICE: begin
        in_service = 1'b1;
        if (rti_retire)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign irq_pending = pending_q;

endmodule
